// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_sequencer
//  Description : Single-outstanding command stage for the ALU execution units.
//                Issues one-cycle unit enables, collects the flagged result or
//                a timeout, and presents it on a valid/ready result port.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer #(
    parameter int IN_DATA_WIDTH  = 16,
    parameter int OUT_DATA_WIDTH = 16,
    parameter int WAIT_MAX       = 4
) (
    input  logic                      Clk,
    input  logic                      RST,
    input  logic                      Cmd_Valid,
    output logic                      Cmd_Ready,
    input  logic [IN_DATA_WIDTH-1:0]  Cmd_A,
    input  logic [IN_DATA_WIDTH-1:0]  Cmd_B,
    input  logic [3:0]                Cmd_FUN,
    output logic [IN_DATA_WIDTH-1:0]  Unit_A,
    output logic [IN_DATA_WIDTH-1:0]  Unit_B,
    output logic [1:0]                Unit_FUN,
    output logic                      Arith_Enable,
    output logic                      Logic_Enable,
    output logic                      CMP_Enable,
    output logic                      Shift_Enable,
    input  logic [OUT_DATA_WIDTH-1:0] Arith_out,
    input  logic [OUT_DATA_WIDTH-1:0] Logic_out,
    input  logic [OUT_DATA_WIDTH-1:0] CMP_out,
    input  logic [OUT_DATA_WIDTH-1:0] Shift_out,
    input  logic                      Arith_Flag,
    input  logic                      Logic_Flag,
    input  logic                      CMP_Flag,
    input  logic                      Shift_Flag,
    output logic                      Res_Valid,
    input  logic                      Res_Ready,
    output logic [OUT_DATA_WIDTH-1:0] Res_Data,
    output logic                      Res_Err
);

    localparam int             CNT_W    = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                    state;
    logic [1:0]                unit_sel;
    logic [CNT_W-1:0]          wait_cnt;
    logic                      sel_flag;
    logic [OUT_DATA_WIDTH-1:0] sel_out;

    // Only the unit that was issued is observed; the rest are don't-care.
    always_comb begin
        sel_flag = 1'b0;
        sel_out  = '0;
        case (unit_sel)
            2'b00:   begin sel_flag = Arith_Flag; sel_out = Arith_out; end
            2'b01:   begin sel_flag = Logic_Flag; sel_out = Logic_out; end
            2'b10:   begin sel_flag = CMP_Flag;   sel_out = CMP_out;   end
            default: begin sel_flag = Shift_Flag; sel_out = Shift_out; end
        endcase
    end

    always_ff @(posedge Clk or negedge RST) begin
        if (!RST) begin
            state        <= ST_IDLE;
            unit_sel     <= 2'b00;
            wait_cnt     <= '0;
            Cmd_Ready    <= 1'b1;
            Unit_A       <= '0;
            Unit_B       <= '0;
            Unit_FUN     <= 2'b00;
            Arith_Enable <= 1'b0;
            Logic_Enable <= 1'b0;
            CMP_Enable   <= 1'b0;
            Shift_Enable <= 1'b0;
            Res_Valid    <= 1'b0;
            Res_Data     <= '0;
            Res_Err      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Cmd_Valid) begin
                        Unit_A       <= Cmd_A;
                        Unit_B       <= Cmd_B;
                        Unit_FUN     <= Cmd_FUN[1:0];
                        unit_sel     <= Cmd_FUN[3:2];
                        // Enable is registered here so it is high exactly during ISSUE.
                        Arith_Enable <= (Cmd_FUN[3:2] == 2'b00);
                        Logic_Enable <= (Cmd_FUN[3:2] == 2'b01);
                        CMP_Enable   <= (Cmd_FUN[3:2] == 2'b10);
                        Shift_Enable <= (Cmd_FUN[3:2] == 2'b11);
                        Cmd_Ready    <= 1'b0;
                        state        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    Arith_Enable <= 1'b0;
                    Logic_Enable <= 1'b0;
                    CMP_Enable   <= 1'b0;
                    Shift_Enable <= 1'b0;
                    wait_cnt     <= '0;
                    state        <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (sel_flag) begin
                        Res_Data  <= sel_out;
                        Res_Err   <= 1'b0;
                        Res_Valid <= 1'b1;
                        state     <= ST_DONE;
                    end else if (wait_cnt == CNT_LAST) begin
                        Res_Data  <= '0;
                        Res_Err   <= 1'b1;
                        Res_Valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        wait_cnt  <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    if (Res_Ready) begin
                        Res_Valid <= 1'b0;
                        Cmd_Ready <= 1'b1;
                        wait_cnt  <= '0;
                        state     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire
